// File: rtl/mc_control_unit.sv
// mc_control_unit: multi-cycle Moore controller for the RISC-V core.
// Combines the main instruction sequencer with the ALU operation decoder
// and keeps a wrapping count of retired instructions.
//
// Handshakes:
//   fetch:  an instruction is accepted on a cycle where
//           instr_valid_i & instr_ready_o are both high.
//   memory: a MEM_RD/MEM_WR access completes on a cycle where mem_ready_i is high
//           (with MEM_WAIT = 0 the access always completes after one cycle).
module mc_control_unit #(
    parameter int CNT_W    = 16,
    parameter bit MEM_WAIT = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             instr_valid_i,
    input  logic [6:0]       opcode_i,
    input  logic [3:0]       funct_i,
    input  logic             mem_ready_i,
    output logic             instr_ready_o,
    output logic             ir_write_o,
    output logic             pc_write_o,
    output logic             branch_o,
    output logic             alu_src_b_o,
    output logic [3:0]       alu_operation_o,
    output logic             mem_read_o,
    output logic             mem_write_o,
    output logic             mem_to_reg_o,
    output logic             reg_write_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] retired_o,
    output logic [3:0]       state_o
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALU_WB   = 4'd8,
        S_BRANCH   = 4'd9,
        S_TRAP     = 4'd10
    } state_e;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;

    state_e             state_q, state_d;
    logic [6:0]         opcode_q;
    logic [3:0]         funct_q;
    logic               illegal_q;
    logic [CNT_W-1:0]   retired_q;
    logic               fetch_hs;
    logic               mem_done;
    logic               retire;

    // R-type map; unlisted funct codes fall back to ADD rather than trapping.
    function automatic logic [3:0] r_alu(input logic [3:0] f);
        case (f)
            4'b0000: r_alu = ALU_ADD;
            4'b1000: r_alu = ALU_SUB;
            4'b0111: r_alu = ALU_AND;
            4'b0110: r_alu = ALU_OR;
            4'b0100: r_alu = ALU_XOR;
            4'b0010: r_alu = ALU_SLT;
            4'b0001: r_alu = ALU_SLL;
            4'b0101: r_alu = ALU_SRL;
            4'b1101: r_alu = ALU_SRA;
            default: r_alu = ALU_ADD;
        endcase
    endfunction

    // I-type: instr[30] only distinguishes SRL/SRA; elsewhere it is immediate bits.
    function automatic logic [3:0] i_alu(input logic [3:0] f);
        if (f[2:0] == 3'b101) i_alu = r_alu(f);
        else                  i_alu = r_alu({1'b0, f[2:0]});
    endfunction

    assign fetch_hs = (state_q == S_FETCH) && instr_valid_i;
    assign mem_done = (MEM_WAIT == 1'b0) || mem_ready_i;
    assign retire   = (state_q != S_FETCH) && (state_d == S_FETCH);

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_FETCH;
        else         state_q <= state_d;
    end

    // Latched instruction fields, sticky illegal flag and retire counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            opcode_q  <= '0;
            funct_q   <= '0;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            if (fetch_hs) begin
                opcode_q <= opcode_i;
                funct_q  <= funct_i;
            end
            if ((state_q == S_DECODE) && (state_d == S_TRAP)) illegal_q <= 1'b1;
            if (retire) retired_q <= retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Next-state decode from the latched opcode.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH:    if (instr_valid_i) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode_q)
                    OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
                    OP_RTYPE:          state_d = S_EXEC_R;
                    OP_ITYPE:          state_d = S_EXEC_I;
                    OP_BEQ:            state_d = S_BRANCH;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEM_ADDR: state_d = (opcode_q == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem_done) state_d = S_MEM_WB;
            S_MEM_WR:   if (mem_done) state_d = S_FETCH;
            S_MEM_WB:   state_d = S_FETCH;
            S_EXEC_R:   state_d = S_ALU_WB;
            S_EXEC_I:   state_d = S_ALU_WB;
            S_ALU_WB:   state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_FETCH;
        endcase
    end

    // Moore outputs from the registered state; only ir/pc write see instr_valid.
    always_comb begin
        instr_ready_o   = 1'b0;
        ir_write_o      = 1'b0;
        pc_write_o      = 1'b0;
        branch_o        = 1'b0;
        alu_src_b_o     = 1'b0;
        alu_operation_o = ALU_ADD;
        mem_read_o      = 1'b0;
        mem_write_o     = 1'b0;
        mem_to_reg_o    = 1'b0;
        reg_write_o     = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                instr_ready_o = 1'b1;
                ir_write_o    = instr_valid_i;
                pc_write_o    = instr_valid_i;
            end
            S_MEM_ADDR: alu_src_b_o = 1'b1;
            S_MEM_RD:   mem_read_o  = 1'b1;
            S_MEM_WR:   mem_write_o = 1'b1;
            S_MEM_WB: begin
                mem_to_reg_o = 1'b1;
                reg_write_o  = 1'b1;
            end
            S_EXEC_R:   alu_operation_o = r_alu(funct_q);
            S_EXEC_I: begin
                alu_src_b_o     = 1'b1;
                alu_operation_o = i_alu(funct_q);
            end
            S_ALU_WB: begin
                reg_write_o = 1'b1;
                if (opcode_q == OP_ITYPE) begin
                    alu_src_b_o     = 1'b1;
                    alu_operation_o = i_alu(funct_q);
                end else begin
                    alu_operation_o = r_alu(funct_q);
                end
            end
            S_BRANCH: begin
                branch_o        = 1'b1;
                alu_operation_o = ALU_SUB;
            end
            default: ;
        endcase
    end

    assign illegal_o = illegal_q;
    assign retired_o = retired_q;
    assign state_o   = state_q;

endmodule
